// File: rtl/cv32e40p_3voter_fault_tracker.sv
// Fault tracker beside the 3-input majority voter: per-replica error counters
// with decay, broken-replica selection and escalation to a fatal state.
module cv32e40p_3voter_fault_tracker #(
   parameter int CNT_W        = 4,
   parameter int THRESHOLD    = 8,
   parameter int DECAY_PERIOD = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic               err_detected_1_i,
   input  logic               err_detected_2_i,
   input  logic               err_detected_3_i,
   input  logic               err_corrected_i,
   input  logic               clear_i,
   output logic [2:0]         broken_block_o,
   output logic               fatal_o,
   output logic               event_o,
   output logic [1:0]         state_o,
   output logic [3*CNT_W-1:0] err_cnt_o
);

   localparam int TMR_W = $clog2(DECAY_PERIOD + 2);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESHOLD - 1);
   localparam logic [TMR_W-1:0] TMR_END = TMR_W'(DECAY_PERIOD - 1);

   typedef enum logic [1:0] {
      NORMAL   = 2'b00,
      DEGRADED = 2'b01,
      FAILED   = 2'b10
   } state_t;

   state_t                  state;
   logic [2:0][CNT_W-1:0]   cnt;
   logic [TMR_W-1:0]        tmr;
   logic [2:0]              err;
   logic [2:0]              at_thr;
   logic                    multi_err;
   logic                    hit_thr;
   logic                    unused_corr;

   // The correction flag carries no information the per-replica flags lack.
   assign unused_corr = err_corrected_i;

   assign err       = {err_detected_3_i, err_detected_2_i, err_detected_1_i};
   assign multi_err = (err[0] & err[1]) | (err[0] & err[2]) | (err[1] & err[2]);

   always_comb begin
      at_thr = '0;
      for (int i = 0; i < 3; i++) at_thr[i] = (cnt[i] == CNT_THR);
   end
   assign hit_thr = |(err & at_thr);

   assign state_o   = state;
   assign err_cnt_o = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= NORMAL;
         cnt            <= '0;
         tmr            <= '0;
         broken_block_o <= '0;
         fatal_o        <= 1'b0;
         event_o        <= 1'b0;
      end else begin
         event_o <= 1'b0;
         if (clear_i) begin
            state          <= NORMAL;
            cnt            <= '0;
            tmr            <= '0;
            broken_block_o <= '0;
            fatal_o        <= 1'b0;
         end else if (valid_i) begin
            case (state)
               NORMAL: begin
                  if (multi_err) begin
                     state   <= FAILED;
                     fatal_o <= 1'b1;
                     event_o <= 1'b1;
                  end else if (|err) begin
                     tmr <= '0;
                     if (hit_thr) begin
                        state          <= DEGRADED;
                        broken_block_o <= err;
                        cnt            <= '0;
                        event_o        <= 1'b1;
                     end else begin
                        for (int i = 0; i < 3; i++)
                           if (err[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
                     end
                  end else if (DECAY_PERIOD != 0) begin
                     if (tmr == TMR_END) begin
                        tmr <= '0;
                        for (int i = 0; i < 3; i++)
                           if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
                     end else begin
                        tmr <= tmr + 1'b1;
                     end
                  end
               end
               // The broken replica's flag is undriven here, so it is masked.
               DEGRADED: begin
                  if (|(err & ~broken_block_o)) begin
                     state   <= FAILED;
                     fatal_o <= 1'b1;
                     event_o <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
